// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Captures the decoded instruction and its operands. Forwards results from
// EX/MEM and MEM/WB into the EX operands, and inserts a bubble on a load-use
// hazard. Also handles flush (taken branch/JR) and hold (downstream stall).
module id_ex_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000,
    parameter int          FWD_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instruction,
    input  logic        id_valid,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic        flush,
    input  logic        hold,
    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_wr_addr,
    input  logic [31:0] exmem_wr_data,
    input  logic        exmem_is_load,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_wr_addr,
    input  logic [31:0] memwb_wr_data,
    output logic [31:0] ex_instruction,
    output logic        ex_valid,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [4:0]  ex_dest,
    output logic        ex_is_load,
    output logic        id_stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;

    logic [5:0] ex_op;
    logic [4:0] ex_rs_f;
    logic [4:0] ex_rt_f;
    logic [4:0] ex_rd_f;
    logic [5:0] ex_func;
    logic [5:0] id_op;
    logic [4:0] id_rs_f;
    logic [4:0] id_rt_f;

    logic       id_reads_rt;
    logic       load_use;
    logic       wb_hits_ex_rs;
    logic       wb_hits_ex_rt;
    logic       wb_hits_id_rs;
    logic       wb_hits_id_rt;
    logic [4:0] dest_c;
    logic       unused_bits;

    assign ex_op   = instr_q[31:26];
    assign ex_rs_f = instr_q[25:21];
    assign ex_rt_f = instr_q[20:16];
    assign ex_rd_f = instr_q[15:11];
    assign ex_func = instr_q[5:0];
    assign id_op   = id_instruction[31:26];
    assign id_rs_f = id_instruction[25:21];
    assign id_rt_f = id_instruction[20:16];

    assign unused_bits = ^{id_instruction[15:0], instr_q[10:6]};

    // Destination register of the EX instruction; zero when it writes nothing
    always_comb begin
        dest_c = 5'd0;
        if (valid_q) begin
            case (ex_op)
                OP_RTYPE: if (ex_func != FN_JR) dest_c = ex_rd_f;
                OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                OP_SLTI, OP_SLTIU, OP_LW: dest_c = ex_rt_f;
                default: dest_c = 5'd0;
            endcase
        end
    end

    // Decide whether the ID instruction actually consumes its rt operand
    always_comb begin
        id_reads_rt = 1'b0;
        case (id_op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: id_reads_rt = 1'b1;
            default: id_reads_rt = 1'b0;
        endcase
    end

    assign ex_dest    = dest_c;
    assign ex_is_load = valid_q && (ex_op == OP_LW);

    assign load_use = valid_q && ex_is_load && id_valid && (dest_c != 5'd0) &&
                      ((dest_c == id_rs_f) || (id_reads_rt && (dest_c == id_rt_f)));

    // EX is empty while in reset, so nothing upstream needs to wait
    assign id_stall = !rst && (hold || (load_use && !flush));

    // A writeback landing on a source register must be captured, since the
    // register file reads before it writes
    assign wb_hits_ex_rs = memwb_wr_en && (ex_rs_f != 5'd0) && (memwb_wr_addr == ex_rs_f);
    assign wb_hits_ex_rt = memwb_wr_en && (ex_rt_f != 5'd0) && (memwb_wr_addr == ex_rt_f);
    assign wb_hits_id_rs = memwb_wr_en && (id_rs_f != 5'd0) && (memwb_wr_addr == id_rs_f);
    assign wb_hits_id_rt = memwb_wr_en && (id_rt_f != 5'd0) && (memwb_wr_addr == id_rt_f);

    // Pipeline register: reset > hold > flush > load-use bubble > normal load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
        end else if (hold) begin
            if (wb_hits_ex_rs) rs_q <= memwb_wr_data;
            if (wb_hits_ex_rt) rt_q <= memwb_wr_data;
        end else if (flush || load_use) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
        end else begin
            instr_q <= id_instruction;
            valid_q <= id_valid;
            rs_q    <= wb_hits_id_rs ? memwb_wr_data : id_rs_val;
            rt_q    <= wb_hits_id_rt ? memwb_wr_data : id_rt_val;
        end
    end

    assign ex_instruction = instr_q;
    assign ex_valid       = valid_q;

    // Forward the rs operand; the newest producer (EX/MEM) wins, $0 never forwards
    always_comb begin
        ex_rs_val = rs_q;
        if ((FWD_EN != 0) && (ex_rs_f != 5'd0)) begin
            if (exmem_wr_en && !exmem_is_load && (exmem_wr_addr == ex_rs_f))
                ex_rs_val = exmem_wr_data;
            else if (memwb_wr_en && (memwb_wr_addr == ex_rs_f))
                ex_rs_val = memwb_wr_data;
        end
    end

    // Forward the rt operand with the same priority as rs
    always_comb begin
        ex_rt_val = rt_q;
        if ((FWD_EN != 0) && (ex_rt_f != 5'd0)) begin
            if (exmem_wr_en && !exmem_is_load && (exmem_wr_addr == ex_rt_f))
                ex_rt_val = exmem_wr_data;
            else if (memwb_wr_en && (memwb_wr_addr == ex_rt_f))
                ex_rt_val = memwb_wr_data;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: one forwarding instance and one
// instance with forwarding disabled, sharing the same stimulus.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        flush;
    logic        hold;
    logic        exmem_wr_en;
    logic [4:0]  exmem_wr_addr;
    logic [31:0] exmem_wr_data;
    logic        exmem_is_load;
    logic        memwb_wr_en;
    logic [4:0]  memwb_wr_addr;
    logic [31:0] memwb_wr_data;

    logic [31:0] ex_instruction, nf_instruction;
    logic        ex_valid, nf_valid;
    logic [31:0] ex_rs_val, nf_rs_val;
    logic [31:0] ex_rt_val, nf_rt_val;
    logic [4:0]  ex_dest, nf_dest;
    logic        ex_is_load, nf_is_load;
    logic        id_stall, nf_stall;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] FN_ADD = 6'b100000;

    localparam logic [31:0] I_SUB_4_3_3   = 32'h00632022;
    localparam logic [31:0] I_ADD_10_5_0  = 32'h00A05020;
    localparam logic [31:0] I_LW_7_0_1    = 32'h8C270000;
    localparam logic [31:0] I_ADD_8_7_2   = 32'h00E24020;
    localparam logic [31:0] I_LW_8_0_1    = 32'h8C280000;
    localparam logic [31:0] I_ADDI_8_2_1  = 32'h20480001;
    localparam logic [31:0] I_SW_8_0_2    = 32'hAC480000;
    localparam logic [31:0] I_ADD_9_6_6   = 32'h00C64820;

    always #5 clk = ~clk;

    id_ex_stage #(.NOP_INSTR(32'h00000000), .FWD_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .id_instruction(id_instruction), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .flush(flush), .hold(hold),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
        .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
        .memwb_wr_data(memwb_wr_data),
        .ex_instruction(ex_instruction), .ex_valid(ex_valid),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_dest(ex_dest), .ex_is_load(ex_is_load), .id_stall(id_stall)
    );

    id_ex_stage #(.NOP_INSTR(32'h00000000), .FWD_EN(0)) u_dut_nofwd (
        .clk(clk), .rst(rst),
        .id_instruction(id_instruction), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .flush(flush), .hold(hold),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
        .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
        .memwb_wr_data(memwb_wr_data),
        .ex_instruction(nf_instruction), .ex_valid(nf_valid),
        .ex_rs_val(nf_rs_val), .ex_rt_val(nf_rt_val),
        .ex_dest(nf_dest), .ex_is_load(nf_is_load), .id_stall(nf_stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                                 input logic [31:0] rsv, input logic [31:0] rtv);
        id_instruction = instr;
        id_valid       = valid;
        id_rs_val      = rsv;
        id_rt_val      = rtv;
    endtask

    task automatic setExMem(input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic is_load);
        exmem_wr_en   = en;
        exmem_wr_addr = addr;
        exmem_wr_data = data;
        exmem_is_load = is_load;
    endtask

    task automatic setMemWb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        memwb_wr_en   = en;
        memwb_wr_addr = addr;
        memwb_wr_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        hold = 1'b0;
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0);
        setExMem(1'b0, 5'd0, 32'h0, 1'b0);
        setMemWb(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("reset_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset_instr", ex_instruction, 32'h0);
        checkOutput("reset_rs", ex_rs_val, 32'h0);
        checkOutput("reset_dest", 32'(ex_dest), 32'd0);
        checkOutput("reset_stall", 32'(id_stall), 32'd0);
        rst = 1'b0;

        // EX/MEM forwarding into both operands
        applyStimulus(I_SUB_4_3_3, 1'b1, 32'h0, 32'h0);
        setExMem(1'b1, 5'd3, 32'h00000010, 1'b0);
        tick();
        checkOutput("exmem_instr", ex_instruction, I_SUB_4_3_3);
        checkOutput("exmem_valid", 32'(ex_valid), 32'd1);
        checkOutput("exmem_dest", 32'(ex_dest), 32'd4);
        checkOutput("exmem_rs", ex_rs_val, 32'h00000010);
        checkOutput("exmem_rt", ex_rt_val, 32'h00000010);
        checkOutput("nofwd_rs", nf_rs_val, 32'h0);
        checkOutput("nofwd_rt", nf_rt_val, 32'h0);

        // Forwarding priority and $0 handling
        setExMem(1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(I_ADD_10_5_0, 1'b1, 32'h11111111, 32'h22222222);
        tick();
        setExMem(1'b1, 5'd5, 32'hAAAA0000, 1'b0);
        setMemWb(1'b1, 5'd5, 32'h5555FFFF);
        #1;
        checkOutput("prio_rs", ex_rs_val, 32'hAAAA0000);
        checkOutput("prio_rt_zero", ex_rt_val, 32'h22222222);
        checkOutput("prio_nofwd_rs", nf_rs_val, 32'h11111111);
        checkOutput("prio_dest", 32'(ex_dest), 32'd10);
        exmem_wr_en = 1'b0;
        #1;
        checkOutput("memwb_only_rs", ex_rs_val, 32'h5555FFFF);
        setExMem(1'b1, 5'd5, 32'hAAAA0000, 1'b1);
        setMemWb(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("exmem_load_noforward", ex_rs_val, 32'h11111111);
        setExMem(1'b1, 5'd0, 32'hAAAA0000, 1'b0);
        setMemWb(1'b1, 5'd0, 32'h5555FFFF);
        #1;
        checkOutput("zero_target_rs", ex_rs_val, 32'h11111111);
        checkOutput("zero_target_rt", ex_rt_val, 32'h22222222);
        setExMem(1'b0, 5'd0, 32'h0, 1'b0);
        setMemWb(1'b0, 5'd0, 32'h0);

        // Load-use hazard: one stall cycle, one bubble
        applyStimulus(I_LW_7_0_1, 1'b1, 32'h0, 32'h0);
        tick();
        checkOutput("lw_is_load", 32'(ex_is_load), 32'd1);
        checkOutput("lw_dest", 32'(ex_dest), 32'd7);
        applyStimulus(I_ADD_8_7_2, 1'b1, 32'h0, 32'h2);
        #1;
        checkOutput("lu_stall", 32'(id_stall), 32'd1);
        tick();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
        checkOutput("lu_bubble_instr", ex_instruction, 32'h0);
        checkOutput("lu_bubble_dest", 32'(ex_dest), 32'd0);
        checkOutput("lu_stall_released", 32'(id_stall), 32'd0);
        setExMem(1'b1, 5'd7, 32'h0, 1'b1);
        tick();
        setExMem(1'b0, 5'd0, 32'h0, 1'b0);
        setMemWb(1'b1, 5'd7, 32'h12345678);
        #1;
        checkOutput("lu_add_instr", ex_instruction, I_ADD_8_7_2);
        checkOutput("lu_add_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu_add_rs", ex_rs_val, 32'h12345678);
        checkOutput("lu_add_rt", ex_rt_val, 32'h00000002);
        checkOutput("lu_add_dest", 32'(ex_dest), 32'd8);
        setMemWb(1'b0, 5'd0, 32'h0);

        // rt matches the load destination but only counts when rt is read
        applyStimulus(I_LW_8_0_1, 1'b1, 32'h0, 32'h0);
        tick();
        applyStimulus(I_ADDI_8_2_1, 1'b1, 32'h0, 32'h0);
        #1;
        checkOutput("addi_no_stall", 32'(id_stall), 32'd0);
        applyStimulus(I_SW_8_0_2, 1'b1, 32'h0, 32'h0);
        #1;
        checkOutput("sw_rt_stall", 32'(id_stall), 32'd1);
        applyStimulus(I_SW_8_0_2, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("invalid_id_no_stall", 32'(id_stall), 32'd0);

        // Flush overrides a load-use hazard
        applyStimulus(rtype(5'd8, 5'd0, 5'd9, FN_ADD), 1'b1, 32'h33, 32'h44);
        #1;
        checkOutput("flush_pre_stall", 32'(id_stall), 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush_stall", 32'(id_stall), 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", 32'(ex_valid), 32'd0);
        checkOutput("flush_instr", ex_instruction, 32'h0);
        checkOutput("flush_rs", ex_rs_val, 32'h0);

        // Hold for three cycles while WB retires $6
        applyStimulus(I_ADD_9_6_6, 1'b1, 32'h1, 32'h1);
        tick();
        hold = 1'b1;
        setMemWb(1'b1, 5'd6, 32'hDEADBEEF);
        applyStimulus(I_SUB_4_3_3, 1'b1, 32'h7, 32'h7);
        #1;
        checkOutput("hold_stall", 32'(id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_instr", ex_instruction, I_ADD_9_6_6);
        end
        hold = 1'b0;
        setMemWb(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("hold_rs", ex_rs_val, 32'hDEADBEEF);
        checkOutput("hold_rt", ex_rt_val, 32'hDEADBEEF);
        checkOutput("hold_nofwd_rs", nf_rs_val, 32'hDEADBEEF);

        // Writeback bypass on a normal load, seen without forwarding
        applyStimulus(rtype(5'd6, 5'd0, 5'd9, FN_ADD), 1'b1, 32'h0, 32'h0);
        setMemWb(1'b1, 5'd6, 32'hCAFE0001);
        tick();
        setMemWb(1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("load_bypass_nofwd_rs", nf_rs_val, 32'hCAFE0001);

        // Reset asserted while a load-use stall is pending
        applyStimulus(I_LW_7_0_1, 1'b1, 32'h0, 32'h0);
        tick();
        applyStimulus(I_ADD_8_7_2, 1'b1, 32'h0, 32'h2);
        #1;
        checkOutput("rst_pre_stall", 32'(id_stall), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_mid_instr", ex_instruction, 32'h0);
        checkOutput("rst_mid_dest", 32'(ex_dest), 32'd0);
        checkOutput("rst_mid_is_load", 32'(ex_is_load), 32'd0);
        checkOutput("rst_mid_stall", 32'(id_stall), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
